// File: rtl/vram_arbiter_if.sv
// Bus bundle between the vector RAM arbiter, the 6502 CPU port, the DVG fetch port
// and the single-port RAM. The arbiter uses the slave modport; the surroundings use master.
interface vram_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic              cpu_en;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_a;
  logic [DATA_W-1:0] cpu_wd;
  logic [DATA_W-1:0] cpu_rd;
  logic              cpu_rdy;

  logic              dvg_req;
  logic [ADDR_W-1:0] dvg_a;
  logic              dvg_ack;
  logic [DATA_W-1:0] dvg_d;

  logic              godvg;
  logic              dvg_halt;
  logic              dvg_busy;
  logic [15:0]       frame_cnt;

  logic [ADDR_W-1:0] ram_a;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wd;
  logic [DATA_W-1:0] ram_rd;

  modport slave (
    input  cpu_en, cpu_we, cpu_a, cpu_wd, dvg_req, dvg_a, godvg, dvg_halt, ram_rd,
    output cpu_rd, cpu_rdy, dvg_ack, dvg_d, dvg_busy, frame_cnt, ram_a, ram_we, ram_wd
  );

  modport master (
    output cpu_en, cpu_we, cpu_a, cpu_wd, dvg_req, dvg_a, godvg, dvg_halt, ram_rd,
    input  cpu_rd, cpu_rdy, dvg_ack, dvg_d, dvg_busy, frame_cnt, ram_a, ram_we, ram_wd
  );
endinterface

// File: rtl/vram_arbiter.sv
// Shares the single-port vector RAM between the 6502 and the DVG fetch port: CPU priority
// with a starvation limit for the DVG, plus GODVG frame counting and DVG busy tracking.
module vram_arbiter #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 8,
  parameter int MAX_CPU_RUN = 3
) (
  input  logic           clk,
  input  logic           reset,
  vram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {OWN_IDLE, OWN_CPU, OWN_DVG} own_e;

  localparam int SW = $clog2(MAX_CPU_RUN + 1);

  own_e              own_q, own_d;
  logic              rd_q, rd_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [DATA_W-1:0] cpu_rd_q, cpu_rd_d;
  logic [DATA_W-1:0] dvg_d_q, dvg_d_d;
  logic              busy_q, busy_d;
  logic [15:0]       frame_q, frame_d;

  logic ack_block;
  logic dvg_elig;
  logic cpu_gnt;
  logic dvg_gnt;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cpu_gnt   = 1'b0;
    dvg_gnt   = 1'b0;
    starve_d  = '0;
    ack_block = (own_q == OWN_DVG);
    dvg_elig  = bus.dvg_req & ~ack_block;

    if (bus.cpu_en && dvg_elig) begin
      if (starve_q == SW'(MAX_CPU_RUN)) begin
        dvg_gnt = 1'b1;
      end else begin
        cpu_gnt  = 1'b1;
        starve_d = starve_q + 1'b1;
      end
    end else if (bus.cpu_en) begin
      cpu_gnt = 1'b1;
    end else if (dvg_elig) begin
      dvg_gnt = 1'b1;
    end

    own_d = OWN_IDLE;
    if (dvg_gnt)      own_d = OWN_DVG;
    else if (cpu_gnt) own_d = OWN_CPU;
    rd_d = cpu_gnt & ~bus.cpu_we;

    // Read data lands on ram_rd the cycle after the grant; steer it by the registered owner.
    cpu_rd_d = cpu_rd_q;
    if (own_q == OWN_CPU && rd_q) cpu_rd_d = bus.ram_rd;
    dvg_d_d = dvg_d_q;
    if (own_q == OWN_DVG) dvg_d_d = bus.ram_rd;

    busy_d = busy_q;
    if (bus.godvg)         busy_d = 1'b1;
    else if (bus.dvg_halt) busy_d = 1'b0;
    frame_d = frame_q + 16'(bus.godvg);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      own_q    <= OWN_IDLE;
      rd_q     <= 1'b0;
      starve_q <= '0;
      cpu_rd_q <= '0;
      dvg_d_q  <= '0;
      busy_q   <= 1'b0;
      frame_q  <= '0;
    end else begin
      own_q    <= own_d;
      rd_q     <= rd_d;
      starve_q <= starve_d;
      cpu_rd_q <= cpu_rd_d;
      dvg_d_q  <= dvg_d_d;
      busy_q   <= busy_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.cpu_rdy   = ~(bus.cpu_en & dvg_gnt);
  assign bus.cpu_rd    = cpu_rd_d;
  assign bus.dvg_ack   = ack_block;
  assign bus.dvg_d     = dvg_d_d;
  assign bus.dvg_busy  = busy_q;
  assign bus.frame_cnt = frame_q;
  assign bus.ram_a     = dvg_gnt ? bus.dvg_a : bus.cpu_a;
  assign bus.ram_we    = cpu_gnt & bus.cpu_we;
  assign bus.ram_wd    = bus.cpu_wd;

endmodule
